// File: rtl/dma_int_status_ctrl_pkg.sv
// Shared definitions for the DMA interrupt-status controller: FSM encoding,
// event bit positions and FIFO entry field offsets.
package dma_int_status_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFetch   = 2'd1,
    StCapture = 2'd2,
    StActive  = 2'd3
  } state_e;

  localparam int unsigned NumEvt     = 4;
  localparam int unsigned EvtOpDone  = 0;
  localparam int unsigned EvtRdErr   = 1;
  localparam int unsigned EvtWrErr   = 2;
  localparam int unsigned EvtInvDesc = 3;

  // Descriptor number occupies the low bits; event bits sit directly above it.
  function automatic int unsigned desc_lsb(int unsigned desc_w);
    desc_lsb = 0;
  endfunction

  function automatic int unsigned evt_lsb(int unsigned desc_w);
    evt_lsb = desc_w;
  endfunction

endpackage

// File: rtl/dma_int_status_ctrl.sv
// Pops DMA interrupt events from the event FIFO, latches them as software-visible
// status, drives a registered irq, and tracks sticky ECC status and a serviced count.
module dma_int_status_ctrl
  import dma_int_status_ctrl_pkg::*;
#(
  parameter int unsigned DESC_NUM_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 8,
  localparam int unsigned FIFO_WIDTH    = DESC_NUM_WIDTH + 4
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      fifo_empty_i,
  input  logic [FIFO_WIDTH-1:0]     fifo_rd_data_i,
  output logic                      fifo_rd_en_o,
  input  logic                      ecc_sb_err_i,
  input  logic                      ecc_db_err_i,
  input  logic [NumEvt-1:0]         int_mask_i,
  input  logic                      int_clr_i,
  input  logic                      ecc_clr_i,
  input  logic                      cnt_clr_i,
  output logic                      int_valid_o,
  output logic [NumEvt-1:0]         int_status_o,
  output logic [DESC_NUM_WIDTH-1:0] int_desc_num_o,
  output logic [1:0]                ecc_status_o,
  output logic [CNT_WIDTH-1:0]      int_count_o,
  output logic                      irq_o
);

  localparam int unsigned DescLsb = desc_lsb(DESC_NUM_WIDTH);
  localparam int unsigned EvtLsb  = evt_lsb(DESC_NUM_WIDTH);

  state_e                    state_q, state_d;
  logic                      int_valid_q, int_valid_d;
  logic [NumEvt-1:0]         int_status_q, int_status_d;
  logic [DESC_NUM_WIDTH-1:0] int_desc_q, int_desc_d;
  logic [1:0]                ecc_q, ecc_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      irq_q, irq_d;
  logic                      cnt_inc;

  logic [NumEvt-1:0]         rd_evt;
  logic [DESC_NUM_WIDTH-1:0] rd_desc;

  assign rd_evt  = fifo_rd_data_i[EvtLsb +: NumEvt];
  assign rd_desc = fifo_rd_data_i[DescLsb +: DESC_NUM_WIDTH];

  always_comb begin
    state_d      = state_q;
    int_valid_d  = int_valid_q;
    int_status_d = int_status_q;
    int_desc_d   = int_desc_q;
    fifo_rd_en_o = 1'b0;
    cnt_inc      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty_i) state_d = StFetch;
      end
      // Synchronous-read RAM needs one cycle before the head entry is valid.
      StFetch: begin
        state_d = StCapture;
      end
      StCapture: begin
        fifo_rd_en_o = 1'b1;
        if (|(rd_evt & ~int_mask_i)) begin
          int_valid_d  = 1'b1;
          int_status_d = rd_evt;
          int_desc_d   = rd_desc;
          cnt_inc      = 1'b1;
          state_d      = StActive;
        end else begin
          state_d = StIdle;
        end
      end
      StActive: begin
        if (int_clr_i) begin
          int_valid_d  = 1'b0;
          int_status_d = '0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // A new error pulse wins over a clear in the same cycle.
  assign ecc_d = (ecc_clr_i ? 2'b00 : ecc_q) | {ecc_db_err_i, ecc_sb_err_i};

  assign irq_d = (int_valid_q & |(int_status_q & ~int_mask_i)) | ecc_q[1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      int_valid_q  <= 1'b0;
      int_status_q <= '0;
      int_desc_q   <= '0;
      ecc_q        <= '0;
      cnt_q        <= '0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      int_valid_q  <= int_valid_d;
      int_status_q <= int_status_d;
      int_desc_q   <= int_desc_d;
      ecc_q        <= ecc_d;
      cnt_q        <= cnt_d;
      irq_q        <= irq_d;
    end
  end

  assign int_valid_o    = int_valid_q;
  assign int_status_o   = int_status_q;
  assign int_desc_num_o = int_desc_q;
  assign ecc_status_o   = ecc_q;
  assign int_count_o    = cnt_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_dma_int_status_ctrl.sv
// Directed bench for dma_int_status_ctrl with a small synchronous-read FIFO model.
module tb_dma_int_status_ctrl;

  localparam int unsigned DW = 5;
  localparam int unsigned FW = DW + 4;
  localparam int unsigned CW = 8;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          fifo_empty;
  logic [FW-1:0] fifo_rd_data;
  logic          fifo_rd_en;
  logic          ecc_sb_err = 1'b0;
  logic          ecc_db_err = 1'b0;
  logic [3:0]    int_mask = 4'h0;
  logic          int_clr = 1'b0;
  logic          ecc_clr = 1'b0;
  logic          cnt_clr = 1'b0;
  logic          int_valid;
  logic [3:0]    int_status;
  logic [DW-1:0] int_desc_num;
  logic [1:0]    ecc_status;
  logic [CW-1:0] int_count;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;

  dma_int_status_ctrl #(.DESC_NUM_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_data_i (fifo_rd_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .ecc_sb_err_i   (ecc_sb_err),
    .ecc_db_err_i   (ecc_db_err),
    .int_mask_i     (int_mask),
    .int_clr_i      (int_clr),
    .ecc_clr_i      (ecc_clr),
    .cnt_clr_i      (cnt_clr),
    .int_valid_o    (int_valid),
    .int_status_o   (int_status),
    .int_desc_num_o (int_desc_num),
    .ecc_status_o   (ecc_status),
    .int_count_o    (int_count),
    .irq_o          (irq)
  );

  always #5 clock = ~clock;

  // FIFO model: 32 entries, head registered one cycle after the pointer moves.
  logic [FW-1:0] mem [32];
  int wr_ptr = 0;
  int rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr       <= 0;
      fifo_rd_data <= '0;
    end else if (fifo_rd_en) begin
      rd_ptr       <= rd_ptr + 1;
      fifo_rd_data <= mem[(rd_ptr + 1) % 32];
    end else begin
      fifo_rd_data <= mem[rd_ptr % 32];
    end
  end

  // Pop monitor: count pops, pops while empty, and minimum pop spacing.
  int cyc = 0;
  int pops = 0;
  int bad_pops = 0;
  int last_pop = -100;
  int min_gap = 1000;
  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      pops <= pops + 1;
      if (fifo_empty) bad_pops <= bad_pops + 1;
      if (cyc - last_pop < min_gap) min_gap <= cyc - last_pop;
      last_pop <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] evt, input logic [DW-1:0] desc);
    mem[wr_ptr % 32] = {evt, desc};
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!int_valid && k < 20) begin
      tick();
      k++;
    end
    if (!int_valid) check(tag, 32'(int_valid), 32'd1);
  endtask

  task automatic ack();
    int_clr = 1'b1;
    tick();
    int_clr = 1'b0;
  endtask

  initial begin
    int p0;
    tick(2);
    check("rst_valid", 32'(int_valid), 0);
    check("rst_status", 32'(int_status), 0);
    check("rst_desc", 32'(int_desc_num), 0);
    check("rst_ecc", 32'(ecc_status), 0);
    check("rst_cnt", 32'(int_count), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_rden", 32'(fifo_rd_en), 0);
    resetn = 1'b1;
    tick(2);

    // Single event
    push(4'b0001, 5'd5);
    tick();
    check("t1_rden_early", 32'(fifo_rd_en), 0);
    tick();
    check("t1_rden", 32'(fifo_rd_en), 1);
    tick();
    check("t1_rden_once", 32'(fifo_rd_en), 0);
    check("t1_valid", 32'(int_valid), 1);
    check("t1_status", 32'(int_status), 32'h1);
    check("t1_desc", 32'(int_desc_num), 5);
    check("t1_cnt", 32'(int_count), 1);
    check("t1_irq_lag", 32'(irq), 0);
    check("t1_empty", 32'(fifo_empty), 1);
    tick();
    check("t1_irq", 32'(irq), 1);
    ack();
    check("t1_valid_clr", 32'(int_valid), 0);
    check("t1_status_clr", 32'(int_status), 0);
    check("t1_desc_hold", 32'(int_desc_num), 5);
    tick();
    check("t1_irq_clr", 32'(irq), 0);
    check("t1_pops", 32'(pops), 1);

    // Back-to-back
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("t2_cnt_clr", 32'(int_count), 0);
    push(4'b0001, 5'd1);
    push(4'b0001, 5'd2);
    push(4'b0001, 5'd3);
    for (int i = 1; i <= 3; i++) begin
      wait_valid("t2_wait");
      check($sformatf("t2_desc%0d", i), 32'(int_desc_num), 32'(i));
      tick();
      ack();
    end
    tick(2);
    check("t2_empty", 32'(fifo_empty), 1);
    check("t2_cnt", 32'(int_count), 3);
    check("t2_gap_ge4", 32'(min_gap >= 4), 1);

    // Masked discard, then partially masked entry
    int_mask = 4'b0001;
    p0 = pops;
    push(4'b0001, 5'd7);
    tick(6);
    check("t3_popped", 32'(pops - p0), 1);
    check("t3_valid", 32'(int_valid), 0);
    check("t3_irq", 32'(irq), 0);
    check("t3_cnt", 32'(int_count), 3);
    push(4'b0011, 5'd8);
    wait_valid("t3_wait");
    check("t3b_status", 32'(int_status), 32'h3);
    check("t3b_desc", 32'(int_desc_num), 8);
    tick();
    check("t3b_irq", 32'(irq), 1);
    ack();
    int_mask = 4'b0000;
    tick(2);

    // Mask change while ACTIVE
    push(4'b0100, 5'd9);
    wait_valid("t4_wait");
    tick();
    check("t4_irq", 32'(irq), 1);
    int_mask = 4'b0100;
    tick();
    check("t4_irq_masked", 32'(irq), 0);
    check("t4_valid", 32'(int_valid), 1);
    int_mask = 4'b0000;
    tick();
    check("t4_irq_back", 32'(irq), 1);
    ack();
    tick(2);

    // ECC sticky status
    ecc_db_err = 1'b1;
    tick();
    ecc_db_err = 1'b0;
    check("t5_ecc_db", 32'(ecc_status), 32'h2);
    tick();
    check("t5_irq_db", 32'(irq), 1);
    ecc_clr = 1'b1;
    ecc_sb_err = 1'b1;
    tick();
    ecc_clr = 1'b0;
    ecc_sb_err = 1'b0;
    check("t5_ecc_sb", 32'(ecc_status), 32'h1);
    tick();
    check("t5_irq_sb", 32'(irq), 0);

    // Saturation
    for (int i = 0; i < 260; i++) begin
      push(4'b1000, 5'(i));
      wait_valid("t6_wait");
      ack();
    end
    tick(2);
    check("t6_sat", 32'(int_count), 255);

    // cnt_clr and int_clr together with a capture
    push(4'b0010, 5'd17);
    for (int k = 0; k < 10 && !fifo_rd_en; k++) tick();
    check("t6_capture_seen", 32'(fifo_rd_en), 1);
    cnt_clr = 1'b1;
    int_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    int_clr = 1'b0;
    check("t6_cnt_clr_prio", 32'(int_count), 0);
    check("t6_clr_ignored", 32'(int_valid), 1);
    check("t6_desc", 32'(int_desc_num), 17);

    // Reset mid-ACTIVE
    ecc_db_err = 1'b1;
    tick(2);
    ecc_db_err = 1'b0;
    check("t7_irq_pre", 32'(irq), 1);
    p0 = pops;
    resetn = 1'b0;
    wr_ptr = 0;
    #2;
    check("t7_valid", 32'(int_valid), 0);
    check("t7_status", 32'(int_status), 0);
    check("t7_desc", 32'(int_desc_num), 0);
    check("t7_ecc", 32'(ecc_status), 0);
    check("t7_cnt", 32'(int_count), 0);
    check("t7_irq", 32'(irq), 0);
    tick(2);
    resetn = 1'b1;
    tick(4);
    check("t7_idle_valid", 32'(int_valid), 0);
    check("t7_no_pop", 32'(pops - p0), 0);
    check("t7_irq_post", 32'(irq), 0);

    check("no_pop_when_empty", 32'(bad_pops), 0);
    check("gap_final_ge4", 32'(min_gap >= 4), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected $finish before 200000");
    $fatal(1);
  end

endmodule
